// File: rtl/sram_port_pkg.sv
// Shared types and widths for the SRAM port responder and its wait counter.
package sram_port_pkg;

  localparam int unsigned SRAM_AW = 20;
  localparam int unsigned SRAM_DW = 32;
  localparam int unsigned SRAM_BW = 4;
  localparam int unsigned CNT_W   = 4;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StRd      = 3'd1,
    StWrSetup = 3'd2,
    StWrPulse = 3'd3,
    StWrHold  = 3'd4
  } state_e;

endpackage

// File: rtl/sram_wait_cnt.sv
// Loadable down-counter timing each phase of an SRAM access; saturates at zero.
module sram_wait_cnt
  import sram_port_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/sram_port_ctrl.sv
// Responder for one arbiter SRAM port: runs timed reads/writes on an async 1M x 32 SRAM.
// Every chip-facing output comes straight from a flop.
module sram_port_ctrl
  import sram_port_pkg::*;
#(
  parameter int unsigned READ_CYCLES = 2,
  parameter int unsigned WR_SETUP    = 1,
  parameter int unsigned WR_PULSE    = 1,
  parameter int unsigned WR_HOLD     = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               read_ce_i,
  input  logic               write_ce_i,
  input  logic [SRAM_AW-1:0] addr_i,
  input  logic [SRAM_DW-1:0] wdata_i,
  input  logic [SRAM_BW-1:0] be_n_i,
  output logic [SRAM_DW-1:0] rdata_o,
  output logic               busy_o,
  output logic               done_o,
  output logic [SRAM_AW-1:0] sram_addr_o,
  output logic [SRAM_DW-1:0] sram_dout_o,
  input  logic [SRAM_DW-1:0] sram_din_i,
  output logic               sram_doe_o,
  output logic               sram_ce_n_o,
  output logic               sram_oe_n_o,
  output logic               sram_we_n_o,
  output logic [SRAM_BW-1:0] sram_be_n_o
);

  localparam logic [CNT_W-1:0] RdLoad = CNT_W'(READ_CYCLES - 1);
  localparam logic [CNT_W-1:0] WsLoad = CNT_W'(WR_SETUP - 1);
  localparam logic [CNT_W-1:0] WpLoad = CNT_W'(WR_PULSE - 1);
  localparam logic [CNT_W-1:0] WhLoad = CNT_W'(WR_HOLD - 1);

  state_e             state_q, state_d;
  logic [SRAM_AW-1:0] addr_q, addr_d;
  logic [SRAM_DW-1:0] dout_q, dout_d;
  logic [SRAM_DW-1:0] rdata_q, rdata_d;
  logic [SRAM_BW-1:0] be_n_q, be_n_d;
  logic               ce_n_q, ce_n_d;
  logic               oe_n_q, oe_n_d;
  logic               we_n_q, we_n_d;
  logic               doe_q, doe_d;
  logic               done_q, done_d;

  logic               cnt_load;
  logic [CNT_W-1:0]   cnt_load_val;
  logic               cnt_dec;
  logic               cnt_zero;

  sram_wait_cnt u_wait_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    dout_d       = dout_q;
    rdata_d      = rdata_q;
    be_n_d       = be_n_q;
    ce_n_d       = ce_n_q;
    oe_n_d       = oe_n_q;
    we_n_d       = we_n_q;
    doe_d        = doe_q;
    done_d       = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Write takes priority when both requests are raised together.
        if (write_ce_i) begin
          state_d      = StWrSetup;
          addr_d       = addr_i;
          dout_d       = wdata_i;
          be_n_d       = be_n_i;
          ce_n_d       = 1'b0;
          doe_d        = 1'b1;
          cnt_load     = 1'b1;
          cnt_load_val = WsLoad;
        end else if (read_ce_i) begin
          state_d      = StRd;
          addr_d       = addr_i;
          be_n_d       = '0;
          ce_n_d       = 1'b0;
          oe_n_d       = 1'b0;
          doe_d        = 1'b0;
          cnt_load     = 1'b1;
          cnt_load_val = RdLoad;
        end
      end
      StRd: begin
        if (cnt_zero) begin
          rdata_d = sram_din_i;
          done_d  = 1'b1;
          ce_n_d  = 1'b1;
          oe_n_d  = 1'b1;
          be_n_d  = '1;
          state_d = StIdle;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      StWrSetup: begin
        if (cnt_zero) begin
          we_n_d       = 1'b0;
          state_d      = StWrPulse;
          cnt_load     = 1'b1;
          cnt_load_val = WpLoad;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      StWrPulse: begin
        if (cnt_zero) begin
          we_n_d       = 1'b1;
          state_d      = StWrHold;
          cnt_load     = 1'b1;
          cnt_load_val = WhLoad;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      StWrHold: begin
        if (cnt_zero) begin
          doe_d   = 1'b0;
          ce_n_d  = 1'b1;
          be_n_d  = '1;
          done_d  = 1'b1;
          state_d = StIdle;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      dout_q  <= '0;
      rdata_q <= '0;
      be_n_q  <= '1;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      doe_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
      rdata_q <= rdata_d;
      be_n_q  <= be_n_d;
      ce_n_q  <= ce_n_d;
      oe_n_q  <= oe_n_d;
      we_n_q  <= we_n_d;
      doe_q   <= doe_d;
      done_q  <= done_d;
    end
  end

  assign busy_o      = (state_q != StIdle);
  assign done_o      = done_q;
  assign rdata_o     = rdata_q;
  assign sram_addr_o = addr_q;
  assign sram_dout_o = dout_q;
  assign sram_doe_o  = doe_q;
  assign sram_ce_n_o = ce_n_q;
  assign sram_oe_n_o = oe_n_q;
  assign sram_we_n_o = we_n_q;
  assign sram_be_n_o = be_n_q;

endmodule

// File: tb/tb_sram_port_ctrl.sv
// Directed bench: default-timing instance plus a slow (all-15) instance, selected by sel.
module tb_sram_port_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic        read_ce = 1'b0;
  logic        write_ce = 1'b0;
  logic [19:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  be_n = 4'hF;
  logic [31:0] din_val = '0;

  int checks = 0;
  int failures = 0;
  int viol = 0;

  always #5 clk = ~clk;

  logic [31:0] rdata_a, rdata_b, dout_a, dout_b, din_a, din_b;
  logic [19:0] saddr_a, saddr_b;
  logic [3:0]  sbe_a, sbe_b;
  logic        busy_a, busy_b, done_a, done_b, doe_a, doe_b;
  logic        ce_a, ce_b, oe_a, oe_b, we_a, we_b;

  assign din_a = (!ce_a && !oe_a) ? din_val : 32'h0;
  assign din_b = (!ce_b && !oe_b) ? din_val : 32'h0;

  sram_port_ctrl dut (
    .clk (clk), .rst (rst),
    .read_ce_i (read_ce & ~sel), .write_ce_i (write_ce & ~sel),
    .addr_i (addr), .wdata_i (wdata), .be_n_i (be_n),
    .rdata_o (rdata_a), .busy_o (busy_a), .done_o (done_a),
    .sram_addr_o (saddr_a), .sram_dout_o (dout_a), .sram_din_i (din_a),
    .sram_doe_o (doe_a), .sram_ce_n_o (ce_a), .sram_oe_n_o (oe_a),
    .sram_we_n_o (we_a), .sram_be_n_o (sbe_a)
  );

  sram_port_ctrl #(
    .READ_CYCLES (15), .WR_SETUP (15), .WR_PULSE (15), .WR_HOLD (15)
  ) dut15 (
    .clk (clk), .rst (rst),
    .read_ce_i (read_ce & sel), .write_ce_i (write_ce & sel),
    .addr_i (addr), .wdata_i (wdata), .be_n_i (be_n),
    .rdata_o (rdata_b), .busy_o (busy_b), .done_o (done_b),
    .sram_addr_o (saddr_b), .sram_dout_o (dout_b), .sram_din_i (din_b),
    .sram_doe_o (doe_b), .sram_ce_n_o (ce_b), .sram_oe_n_o (oe_b),
    .sram_we_n_o (we_b), .sram_be_n_o (sbe_b)
  );

  wire [31:0] o_rdata = sel ? rdata_b : rdata_a;
  wire [31:0] o_dout  = sel ? dout_b  : dout_a;
  wire [19:0] o_saddr = sel ? saddr_b : saddr_a;
  wire [3:0]  o_be    = sel ? sbe_b   : sbe_a;
  wire        o_busy  = sel ? busy_b  : busy_a;
  wire        o_done  = sel ? done_b  : done_a;
  wire        o_doe   = sel ? doe_b   : doe_a;
  wire        o_ce    = sel ? ce_b    : ce_a;
  wire        o_oe    = sel ? oe_b    : oe_a;
  wire        o_we    = sel ? we_b    : we_a;

  always @(negedge clk) begin
    if ((!we_a && !oe_a) || (!we_b && !oe_b)) viol++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic        sel;
    logic [19:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be_n;
    logic [31:0] din;
    int          lat;
    int          oe_lo;
    int          we_lo;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[7];

  // One access: accept, scramble inputs while busy, watch pins each cycle until done.
  task automatic do_access(input vec_t v, input string nm);
    int n = 0, oe_lo = 0, we_lo = 0, busy_hi = 0, err = 0;
    @(negedge clk);
    sel = v.sel; read_ce = v.rd; write_ce = v.wr;
    addr = v.addr; wdata = v.wdata; be_n = v.be_n; din_val = v.din;
    @(posedge clk);
    @(negedge clk);
    read_ce = 1'b0; write_ce = 1'b0;
    addr = ~v.addr; wdata = ~v.wdata; be_n = ~v.be_n;
    while (!o_done && n < 200) begin
      if (o_busy) begin
        busy_hi++;
        if (o_saddr !== v.addr) err++;
        if (v.wr && (o_ce || !o_doe || o_dout !== v.wdata || o_be !== v.be_n)) err++;
        if (!v.wr && (o_ce || o_oe || o_doe || o_be !== 4'h0)) err++;
      end
      if (!o_oe) oe_lo++;
      if (!o_we) we_lo++;
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    check({nm, "_latency"}, n, v.lat);
    check({nm, "_busy_cycles"}, busy_hi, v.lat);
    check({nm, "_oe_low_cycles"}, oe_lo, v.oe_lo);
    check({nm, "_we_low_cycles"}, we_lo, v.we_lo);
    check({nm, "_pin_errors"}, err, 0);
    check({nm, "_rdata"}, o_rdata, v.exp_rdata);
    @(negedge clk);
    check({nm, "_done_busy_after"}, {o_done, o_busy, o_ce, o_doe}, 4'b0010);
  endtask

  initial begin
    vecs[0] = '{1, 0, 0, 20'h00123, 32'h0, 4'hF, 32'hDEADBEEF, 2, 2, 0, 32'hDEADBEEF};
    vecs[1] = '{0, 1, 0, 20'hFFFFF, 32'hA5A55A5A, 4'b1100, 32'h0, 3, 0, 1, 32'hDEADBEEF};
    vecs[2] = '{1, 1, 0, 20'h00400, 32'h01234567, 4'b0000, 32'hCAFEF00D, 3, 0, 1, 32'hDEADBEEF};
    vecs[3] = '{1, 0, 0, 20'h00000, 32'h0, 4'hF, 32'h12345678, 2, 2, 0, 32'h12345678};
    vecs[4] = '{0, 1, 0, 20'h5A5A5, 32'hFFFFFFFF, 4'b0101, 32'h0, 3, 0, 1, 32'h12345678};
    vecs[5] = '{1, 0, 1, 20'h0ABCD, 32'h0, 4'hF, 32'h87654321, 15, 15, 0, 32'h87654321};
    vecs[6] = '{0, 1, 1, 20'h00001, 32'h0F0F0F0F, 4'b0011, 32'h0, 45, 0, 15, 32'h87654321};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ctrl_pins", {ce_a, oe_a, we_a, sbe_a, doe_a, busy_a, done_a}, 10'b111_1111_000);
    check("rst_addr_dout", {12'h0, saddr_a} | dout_a, 32'h0);
    check("rst_rdata", rdata_a, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_no_request", {busy_a, done_a, ce_a}, 3'b001);

    for (int i = 0; i < 5; i++) do_access(vecs[i], $sformatf("vec%0d", i));

    // Request held through done: re-accepted one edge later with the then-current address
    begin
      int n = 0;
      @(negedge clk);
      read_ce = 1'b1; addr = 20'h11111; din_val = 32'h0BADCAFE;
      @(posedge clk);
      @(negedge clk);
      addr = 20'h22222;
      check("hold_addr_ignored", saddr_a, 20'h11111);
      while (!done_a && n < 50) begin @(posedge clk); n++; @(negedge clk); end
      check("hold_first_latency", n, 2);
      check("hold_first_rdata", rdata_a, 32'h0BADCAFE);
      check("hold_done_edge_idle", busy_a, 1'b0);
      din_val = 32'h600DF00D;
      @(negedge clk);
      check("hold_reaccept", {busy_a, done_a}, 2'b10);
      check("hold_second_addr", saddr_a, 20'h22222);
      read_ce = 1'b0;
      n = 0;
      while (!done_a && n < 50) begin @(posedge clk); n++; @(negedge clk); end
      check("hold_second_latency", n, 2);
      check("hold_second_rdata", rdata_a, 32'h600DF00D);
    end

    // Reset asserted while WE_n is low
    @(negedge clk);
    write_ce = 1'b1; addr = 20'h33333; wdata = 32'h77777777; be_n = 4'h0;
    @(posedge clk);
    @(negedge clk);
    write_ce = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midwr_we_low", we_a, 1'b0);
    rst = 1'b1;
    #1;
    check("midwr_abort_pins", {we_a, ce_a, doe_a, busy_a, done_a}, 5'b11000);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midwr_no_done", {done_a, busy_a}, 2'b00);
    begin
      vec_t v = '{1, 0, 0, 20'h00077, 32'h0, 4'hF, 32'h55AA55AA, 2, 2, 0, 32'h55AA55AA};
      do_access(v, "post_reset_read");
    end

    // Slow-timing instance
    do_access(vecs[5], "slow_read");
    do_access(vecs[6], "slow_write");
    sel = 1'b0;

    check("oe_we_overlap", viol, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_port_ctrl.md
Name: sram_port_ctrl

Overview:
- Responder side of the base/ext SRAM port used by the memory arbiter.
- Takes level-sensitive read/write requests (address, data, byte enables) and runs a timed access on one external asynchronous 1M x 32 SRAM chip: CE_n, OE_n, WE_n, BE_n, address and split data bus.
- Returns registered read data and a one-cycle done pulse. One instance sits behind each of the base and ext ports; the top level owns the data tri-state.

Parameters:
- READ_CYCLES, 2, cycles OE_n/CE_n held low before read data is sampled (legal 1..15).
- WR_SETUP, 1, cycles address/data/CE_n stable before WE_n falls (legal 1..15).
- WR_PULSE, 1, cycles WE_n held low (legal 1..15).
- WR_HOLD, 1, cycles address/data held after WE_n rises (legal 1..15).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- read_ce  in  1  read request, level.
- write_ce  in  1  write request, level; wins over read_ce if both are high.
- addr  in  20  word address.
- wdata  in  32  write data.
- be_n  in  4  write byte enables, active-low.
- rdata  out  32  registered read data.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse on access completion.
- sram_addr  out  20  chip address.
- sram_dout  out  32  data driven to chip.
- sram_din  in  32  data from chip.
- sram_doe  out  1  tri-state enable for sram_dout.
- sram_ce_n  out  1  chip enable.
- sram_oe_n  out  1  output enable.
- sram_we_n  out  1  write enable.
- sram_be_n  out  4  byte enables.

Behaviour:

Reset:
- Asynchronously sets sram_ce_n = 1, sram_oe_n = 1, sram_we_n = 1, sram_be_n = 4'hF, sram_doe = 0, sram_addr = 0, sram_dout = 0, rdata = 0, busy = 0, done = 0, state = IDLE, counter = 0.
- Reset mid-access aborts immediately. No partial-completion done pulse.

Outputs:
- All outputs are registered; no combinational path from inputs to sram_* pins.

States: IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD.
- IDLE:
  - write_ce = 1: latch addr, wdata, be_n; go to WR_SETUP; counter = WR_SETUP - 1.
  - Else read_ce = 1: latch addr; go to RD; counter = READ_CYCLES - 1.
  - Else stay in IDLE.
  - done = 0 on every IDLE edge that accepts nothing.
- RD:
  - sram_ce_n = 0, sram_oe_n = 0, sram_be_n = 4'h0, sram_doe = 0.
  - counter > 0: decrement.
  - counter = 0: rdata <= sram_din, done <= 1, deassert ce_n/oe_n, go to IDLE.
- WR_SETUP:
  - sram_ce_n = 0, sram_doe = 1, sram_dout = latched wdata, sram_be_n = latched be_n, we_n = 1.
  - At counter = 0: go to WR_PULSE; counter = WR_PULSE - 1.
- WR_PULSE:
  - Same drive as WR_SETUP with sram_we_n = 0.
  - At counter = 0: we_n <= 1; go to WR_HOLD; counter = WR_HOLD - 1.
- WR_HOLD:
  - Address, data and CE held; we_n = 1.
  - At counter = 0: sram_doe <= 0, ce_n <= 1, be_n <= F, done <= 1, go to IDLE.

Latency (accept edge = E0):
- Read: done and rdata valid at edge E0 + READ_CYCLES.
- Write: done at edge E0 + WR_SETUP + WR_PULSE + WR_HOLD.
- sram_oe_n and sram_we_n are never low in the same cycle.

Input stability and back-to-back requests:
- Inputs are sampled only at acceptance; changes while busy are ignored.
- Requests are level-sensitive. A request still high in the cycle after done is accepted as a new access, so the requester drops ce on seeing done.
- Minimum one IDLE edge between accesses (the done edge itself never accepts).

Data:
- rdata holds its value until the next read completes; writes do not modify it.
- Counter is 4 bits; no wrap, since it is reloaded at every state entry.

Decomposition:
- Package sram_port_pkg:
  - State encodings: IDLE = 3'd0, RD = 3'd1, WR_SETUP = 3'd2, WR_PULSE = 3'd3, WR_HOLD = 3'd4.
  - SRAM_AW = 20, SRAM_DW = 32, SRAM_BW = 4, CNT_W = 4.
- One sub-module, sram_wait_cnt: loadable 4-bit down-counter with load, value and zero flag, used by every timed state.

Test Plan:
- Reset mid-write: assert rst while in WR_PULSE -> same cycle we_n = 1, ce_n = 1, doe = 0, busy = 0, no done pulse; after release, IDLE accepts a new request normally.
- Single read (READ_CYCLES = 2): addr = 20'h00123, sram_din model = 32'hDEADBEEF -> ce_n/oe_n low for exactly 2 cycles, done at E0+2, rdata = 32'hDEADBEEF, busy high 2 cycles.
- Single write (1/1/1): addr = 20'hFFFFF, wdata = 32'hA5A5_5A5A, be_n = 4'b1100 -> we_n low exactly one cycle, with addr/data/be stable from one cycle before to one cycle after; done at E0+3; rdata unchanged.
- Simultaneous read_ce and write_ce -> write performed, oe_n never low, no rdata update.
- Request held high after done -> second identical access starts on the edge after done; input changes during busy are ignored (sram_addr remains the latched value).
- Parameter sweep (READ_CYCLES = 15, WR_SETUP = WR_PULSE = WR_HOLD = 15) -> read done at E0+15, write done at E0+45; we_n and oe_n never low together (assertion).
